mc_stage_sequencer: RTL

- Parametrised multicycle control sequencer for the MIPS core.
- Drives the one-hot stage strobes IF, ID, REG, EX, MEM and WB, and emits the redirect pulses jump, branch and skip.
- Adds three things the current controller lacks: a memory ready/request handshake with a watchdog timeout, a level-handshaked infer (debug memory read) port, and saturating performance counters.
- Sits between the instruction decoder and the datapath/memory mux in the top level.

---
 rtl/seq_pkg.sv | 49 ++++
 rtl/sat_counter.sv | 19 +
 rtl/mc_stage_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multicycle stage sequencer:
// FSM state encoding, decoded instruction class codes and stage strobe bit positions.
package seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_REG,
    S_EX,
    S_MEM,
    S_WB,
    S_INFER,
    S_INFER_HOLD,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_SKIP   = 3'd5;
  localparam logic [2:0] CLS_HALT   = 3'd6;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_REG = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  function automatic logic [5:0] stage_of(state_t s);
    logic [5:0] oh;
    oh = '0;
    case (s)
      S_IF:    oh[STG_IF]  = 1'b1;
      S_ID:    oh[STG_ID]  = 1'b1;
      S_REG:   oh[STG_REG] = 1'b1;
      S_EX:    oh[STG_EX]  = 1'b1;
      S_MEM:   oh[STG_MEM] = 1'b1;
      S_WB:    oh[STG_WB]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mc_stage_sequencer.sv
// Multicycle control sequencer: walks IF..WB per instruction class, services a debug
// memory read between instructions, guards memory waits with a watchdog, counts activity.
module mc_stage_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              top_en,
  input  logic [2:0]        instr_class,
  input  logic              br_taken,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              infer,
  input  logic [ADDR_W-1:0] infer_addr,
  output logic [5:0]        stage_oh,
  output logic              ju,
  output logic              br,
  output logic              sk,
  output logic              mem_req,
  output logic              infer_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] infer_data,
  output logic              infer_valid,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  state_t            boundary;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        class_q;
  logic              waiting;
  logic              timeout_hit;
  logic              retire;
  logic              ju_ev;
  logic              br_ev;
  logic              sk_ev;
  logic              cycle_en;

  // Handshake: mem_req is a level held for the whole of IF, MEM and INFER; a cycle with
  // mem_req=1 and mem_ready=1 completes the transfer. infer is a level request and
  // infer_valid answers with a level that stays high until infer is released.
  assign boundary    = infer ? S_INFER : S_IF;
  assign waiting     = (state == S_IF) || (state == S_MEM) || (state == S_INFER);
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    ju_ev      = 1'b0;
    br_ev      = 1'b0;
    sk_ev      = 1'b0;
    case (state)
      S_IDLE: next_state = boundary;
      S_IF: begin
        if (mem_ready)        next_state = S_ID;
        else if (timeout_hit) next_state = S_ERR;
      end
      S_ID: begin
        case (instr_class)
          CLS_SKIP: begin next_state = boundary; sk_ev = 1'b1; retire = 1'b1; end
          CLS_JUMP: begin next_state = boundary; ju_ev = 1'b1; retire = 1'b1; end
          CLS_HALT: next_state = S_HALT;
          default:  next_state = S_REG;
        endcase
      end
      S_REG: next_state = S_EX;
      S_EX: begin
        case (class_q)
          CLS_BRANCH: begin next_state = boundary; br_ev = br_taken; retire = 1'b1; end
          CLS_ALU:    next_state = S_WB;
          CLS_LOAD,
          CLS_STORE:  next_state = S_MEM;
          // Undefined codes retire as a skip so the pipeline never stalls on them.
          default:    begin next_state = boundary; sk_ev = 1'b1; retire = 1'b1; end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == CLS_LOAD) begin
            next_state = S_WB;
          end else begin
            next_state = boundary;
            retire     = 1'b1;
          end
        end else if (timeout_hit) begin
          next_state = S_ERR;
        end
      end
      S_WB: begin
        next_state = boundary;
        retire     = 1'b1;
      end
      S_INFER: begin
        if (mem_ready)        next_state = S_INFER_HOLD;
        else if (timeout_hit) next_state = S_ERR;
      end
      S_INFER_HOLD: if (!infer) next_state = S_IF;
      S_HALT, S_ERR: next_state = state;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      class_q    <= '0;
      mem_addr   <= '0;
      infer_data <= '0;
      ju         <= 1'b0;
      br         <= 1'b0;
      sk         <= 1'b0;
    end else begin
      ju <= top_en & ju_ev;
      br <= top_en & br_ev;
      sk <= top_en & sk_ev;
      if (top_en) begin
        state <= next_state;
        if (next_state != state) begin
          wait_cnt <= '0;
        end else if (waiting) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        if (state == S_ID) class_q <= instr_class;
        if ((next_state == S_INFER) && (state != S_INFER)) mem_addr <= infer_addr;
        if ((state == S_INFER) && mem_ready) infer_data <= mem_rdata;
      end
    end
  end

  assign stage_oh    = stage_of(state);
  assign mem_req     = waiting;
  assign infer_sel   = (state == S_INFER);
  assign infer_valid = (state == S_INFER_HOLD);
  assign halted      = (state == S_HALT);
  assign err         = (state == S_ERR);
  assign cycle_en    = top_en && (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cycle_en),
    .cnt   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (top_en & retire),
    .cnt   (instr_cnt)
  );

endmodule
